// File: rtl/execute_pkg.sv
// Shared execute-stage types: multicycle op encoding, default datapath latencies
// and op-classification helpers used by the HI/LO sequencer.
package execute_pkg;

  typedef enum logic [3:0] {
    M_MULT, M_MULTU, M_DIV, M_DIVU,
    M_MADD, M_MADDU, M_MSUB, M_MSUBU,
    M_MTHI, M_MTLO
  } multicycle_t;

  localparam int unsigned MULT_LAT_DEFAULT = 3;
  localparam int unsigned DIV_LAT_DEFAULT  = 33;

  function automatic logic op_is_signed(multicycle_t op);
    return op inside {M_MULT, M_DIV, M_MADD, M_MSUB};
  endfunction

  function automatic logic op_is_div(multicycle_t op);
    return op inside {M_DIV, M_DIVU};
  endfunction

  function automatic logic op_is_accum(multicycle_t op);
    return op inside {M_MADD, M_MADDU, M_MSUB, M_MSUBU};
  endfunction

  function automatic logic op_is_sub(multicycle_t op);
    return op inside {M_MSUB, M_MSUBU};
  endfunction

endpackage

// File: rtl/hilo_sched_if.sv
// Request bus from execute plus the launch/result port of the external
// multiplier/divider, bundled for hilo_sched.
interface hilo_sched_if;
  import execute_pkg::*;

  logic        req_valid;
  logic        req_ready;
  multicycle_t req_op;
  logic [31:0] a;
  logic [31:0] b;
  logic        md_start;
  logic        md_signed;
  logic        md_div;
  logic [31:0] md_a;
  logic [31:0] md_b;
  logic [31:0] md_hi;
  logic [31:0] md_lo;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  // Handshake: a request transfers on a rising clk edge where req_valid && req_ready;
  // req_op/a/b must stay stable while req_valid is high and not yet accepted, and
  // req_ready never depends on req_valid in the same cycle.
  modport master (
    output req_valid, req_op, a, b, md_hi, md_lo,
    input  req_ready, md_start, md_signed, md_div, md_a, md_b, busy, done, hi, lo
  );

  modport slave (
    input  req_valid, req_op, a, b, md_hi, md_lo,
    output req_ready, md_start, md_signed, md_div, md_a, md_b, busy, done, hi, lo
  );

endinterface

// File: rtl/hilo_accum.sv
// 64-bit modulo-2^64 add/subtract of {HI,LO} and a product (MADD/MSUB family).
// Built only when HILO_SCHED_ACCUM_EN is defined.
`ifdef HILO_SCHED_ACCUM_EN
module hilo_accum (
  input  logic [63:0] acc_i,
  input  logic [63:0] prod_i,
  input  logic        sub_i,
  output logic [63:0] sum_o
);
  assign sum_o = sub_i ? (acc_i - prod_i) : (acc_i + prod_i);
endmodule
`endif

// File: rtl/hilo_sched.sv
// Owner of HI/LO and sequencer for multiply/divide/move-to-HI/LO requests.
// Define HILO_SCHED_ACCUM_EN to build MADD/MSUB accumulation (ACC state + hilo_accum).
module hilo_sched
  import execute_pkg::*;
#(
  parameter int unsigned MULT_LAT = MULT_LAT_DEFAULT,
  parameter int unsigned DIV_LAT  = DIV_LAT_DEFAULT
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        flushE,
  hilo_sched_if.slave bus,
  output logic [1:0]  state_o
);

  localparam int unsigned MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);

  localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_LAT);
  localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_LAT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_ACC  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  multicycle_t      op_q, op_d;
  logic [31:0]      a_q, a_d, b_q, b_d;
  logic [31:0]      hi_q, hi_d, lo_q, lo_d;
  logic             launch, commit, launchable;
  multicycle_t      md_op;

`ifdef HILO_SCHED_ACCUM_EN
  logic [63:0] prod_q, prod_d, acc_sum;

  hilo_accum u_accum (
    .acc_i  ({hi_q, lo_q}),
    .prod_i (prod_q),
    .sub_i  (op_is_sub(op_q)),
    .sum_o  (acc_sum)
  );

  assign launchable = 1'b1;
`else
  // Without the accumulator, MADD/MSUB are swallowed in IDLE as no-ops.
  assign launchable = !op_is_accum(bus.req_op);
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    launch  = 1'b0;
    commit  = 1'b0;
`ifdef HILO_SCHED_ACCUM_EN
    prod_d  = prod_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid && !flushE) begin
          if (bus.req_op == M_MTHI) begin
            hi_d = bus.a;
          end else if (bus.req_op == M_MTLO) begin
            lo_d = bus.a;
          end else if (launchable) begin
            launch  = 1'b1;
            op_d    = bus.req_op;
            a_d     = bus.a;
            b_d     = bus.b;
            cnt_d   = op_is_div(bus.req_op) ? DIV_CNT : MULT_CNT;
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (flushE) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
          // The datapath result is valid only in the cycle the counter reads 1.
          if (cnt_q == CNT_ONE) begin
`ifdef HILO_SCHED_ACCUM_EN
            if (op_is_accum(op_q)) begin
              prod_d  = {bus.md_hi, bus.md_lo};
              state_d = S_ACC;
            end else
`endif
            begin
              hi_d    = bus.md_hi;
              lo_d    = bus.md_lo;
              commit  = 1'b1;
              state_d = S_IDLE;
            end
          end
        end
      end
`ifdef HILO_SCHED_ACCUM_EN
      S_ACC: begin
        state_d = S_IDLE;
        if (!flushE) begin
          {hi_d, lo_d} = acc_sum;
          commit       = 1'b1;
        end
      end
`endif
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= M_MULT;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
`ifdef HILO_SCHED_ACCUM_EN
      prod_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
`ifdef HILO_SCHED_ACCUM_EN
      prod_q  <= prod_d;
`endif
    end
  end

  // Operands come straight from the request on launch, then from the latch.
  assign md_op         = (state_q == S_IDLE) ? bus.req_op : op_q;
  assign bus.md_a      = (state_q == S_IDLE) ? bus.a : a_q;
  assign bus.md_b      = (state_q == S_IDLE) ? bus.b : b_q;
  assign bus.md_signed = op_is_signed(md_op);
  assign bus.md_div    = op_is_div(md_op);
  assign bus.md_start  = launch & resetn;
  assign bus.done      = commit & resetn;
  assign bus.req_ready = (state_q == S_IDLE);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_hilo_sched.sv
// Bench for hilo_sched: directed requests, a fixed-latency datapath stand-in,
// and a cycle-level reference model of HI/LO, handshake and done timing.
module tb_hilo_sched;
  import execute_pkg::*;

  localparam int MULT_LAT = 3;
  localparam int DIV_LAT  = 33;
`ifdef HILO_SCHED_ACCUM_EN
  localparam bit ACC_EN = 1'b1;
`else
  localparam bit ACC_EN = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic       clk    = 1'b0;
  logic       resetn = 1'b0;
  logic       flushE = 1'b0;
  logic [1:0] state_dbg;
  int         cyc    = 0;

  hilo_sched_if bus ();

  hilo_sched #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk     (clk),
    .resetn  (resetn),
    .flushE  (flushE),
    .bus     (bus),
    .state_o (state_dbg)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- bookkeeping ----------------
  int n_tests = 0;
  int n_fail  = 0;
  int n_done  = 0;
  int last_done_cyc = -1;
  bit chk_en = 1'b0;
  int issue_waits;
  logic acc_div, acc_sgn;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference arithmetic ----------------
  function automatic logic tb_signed(multicycle_t op);
    case (op)
      M_MULT, M_DIV, M_MADD, M_MSUB: return 1'b1;
      default:                       return 1'b0;
    endcase
  endfunction

  function automatic logic tb_div(multicycle_t op);
    case (op)
      M_DIV, M_DIVU: return 1'b1;
      default:       return 1'b0;
    endcase
  endfunction

  function automatic logic tb_acc(multicycle_t op);
    case (op)
      M_MADD, M_MADDU, M_MSUB, M_MSUBU: return 1'b1;
      default:                          return 1'b0;
    endcase
  endfunction

  function automatic logic tb_sub(multicycle_t op);
    case (op)
      M_MSUB, M_MSUBU: return 1'b1;
      default:         return 1'b0;
    endcase
  endfunction

  function automatic logic tb_launches(multicycle_t op);
    if (op == M_MTHI || op == M_MTLO) return 1'b0;
    if (tb_acc(op) && !ACC_EN) return 1'b0;
    return 1'b1;
  endfunction

  // {HI,LO} a multiplier/divider produces; divide by zero yields {a, all-ones}.
  function automatic logic [63:0] ref_md(input logic dv, input logic sg,
                                         input logic [31:0] x, input logic [31:0] y);
    logic [63:0] ex, ey, q, r;
    longint      sx, sy;
    ex = sg ? {{32{x[31]}}, x} : {32'b0, x};
    ey = sg ? {{32{y[31]}}, y} : {32'b0, y};
    if (!dv) return ex * ey;
    if (y == 32'b0) return {x, 32'hFFFF_FFFF};
    if (sg) begin
      sx = longint'(ex);
      sy = longint'(ey);
      q  = 64'(sx / sy);
      r  = 64'(sx % sy);
    end else begin
      q = ex / ey;
      r = ex % ey;
    end
    return {r[31:0], q[31:0]};
  endfunction

  // ---------------- datapath stand-in: result exactly at T+LAT ----------------
  int          dp_target = -1;
  logic [63:0] dp_res    = 64'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (bus.md_start === 1'b1) begin
        dp_target = cyc + (bus.md_div ? DIV_LAT : MULT_LAT);
        dp_res    = ref_md(bus.md_div, bus.md_signed, bus.md_a, bus.md_b);
      end
    end
  end

  initial begin
    bus.md_hi = 32'hBAD0_BAD0;
    bus.md_lo = 32'hBAD1_BAD1;
    forever begin
      @(posedge clk);
      #1;
      if (cyc == dp_target) {bus.md_hi, bus.md_lo} = dp_res;
      else {bus.md_hi, bus.md_lo} = {32'hBAD0_BAD0, 32'hBAD1_BAD1};
    end
  end

  // ---------------- reference model + per-cycle compare ----------------
  logic [31:0] m_hi = 0, m_lo = 0, m_a = 0, m_b = 0;
  bit          m_busy = 1'b0;
  multicycle_t m_op = M_MULT;
  int          m_t = 0, m_lat = 0, m_done_cyc = -1;

  initial begin
    logic        e_start, e_done;
    logic [63:0] acc, p;
    forever begin
      @(negedge clk);
      e_start = resetn && !flushE && !m_busy && bus.req_valid && tb_launches(bus.req_op);
      e_done  = resetn && !flushE && m_busy && (cyc == m_done_cyc);
      if (chk_en) begin
        chk("req_ready", bus.req_ready, !m_busy);
        chk("busy", bus.busy, m_busy);
        chk("done", bus.done, e_done);
        chk("md_start", bus.md_start, e_start);
        chk("hi", bus.hi, m_hi);
        chk("lo", bus.lo, m_lo);
        if (e_start) begin
          chk("launch_md_a", bus.md_a, bus.a);
          chk("launch_md_b", bus.md_b, bus.b);
          chk("launch_md_signed", bus.md_signed, tb_signed(bus.req_op));
          chk("launch_md_div", bus.md_div, tb_div(bus.req_op));
        end else if (resetn && m_busy && cyc <= m_t + m_lat) begin
          chk("hold_md_a", bus.md_a, m_a);
          chk("hold_md_b", bus.md_b, m_b);
          chk("hold_md_signed", bus.md_signed, tb_signed(m_op));
          chk("hold_md_div", bus.md_div, tb_div(m_op));
        end
      end
      if (bus.done === 1'b1) begin
        n_done++;
        last_done_cyc = cyc;
      end
      // Architectural effect of the edge that ends this cycle.
      if (!resetn) begin
        m_hi = 0; m_lo = 0; m_busy = 1'b0;
      end else if (flushE) begin
        m_busy = 1'b0;
      end else if (m_busy) begin
        if (cyc == m_done_cyc) begin
          if (tb_acc(m_op)) begin
            acc = {m_hi, m_lo};
            p   = ref_md(1'b0, tb_signed(m_op), m_a, m_b);
            acc = tb_sub(m_op) ? acc - p : acc + p;
            {m_hi, m_lo} = acc;
          end else begin
            {m_hi, m_lo} = ref_md(tb_div(m_op), tb_signed(m_op), m_a, m_b);
          end
          m_busy = 1'b0;
        end
      end else if (bus.req_valid) begin
        if (bus.req_op == M_MTHI) m_hi = bus.a;
        else if (bus.req_op == M_MTLO) m_lo = bus.a;
        else if (tb_launches(bus.req_op)) begin
          m_busy     = 1'b1;
          m_op       = bus.req_op;
          m_a        = bus.a;
          m_b        = bus.b;
          m_t        = cyc;
          m_lat      = tb_div(bus.req_op) ? DIV_LAT : MULT_LAT;
          m_done_cyc = cyc + m_lat + (tb_acc(bus.req_op) ? 1 : 0);
        end
      end
    end
  end

  // ---------------- driver tasks (entered/left just after a posedge) ----------------
  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input multicycle_t op, input logic [31:0] xa, input logic [31:0] xb,
                       output int t_acc);
    bit got;
    got = 1'b0;
    t_acc = -1;
    issue_waits = 0;
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.a         = xa;
    bus.b         = xb;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge clk);
      if (bus.req_ready === 1'b1) begin
        got = 1'b1;
        t_acc = cyc;
        acc_div = bus.md_div;
        acc_sgn = bus.md_signed;
      end else begin
        issue_waits++;
      end
      settle();
    end
    bus.req_valid = 1'b0;
    if (!got) chk("issue_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_done(input int limit, output int dc);
    bit got;
    got = 1'b0;
    dc = -1;
    for (int k = 0; k < limit && !got; k++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        got = 1'b1;
        dc = cyc;
      end
      settle();
    end
    if (!got) chk("wait_done_timeout", 64'd0, 64'd1);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  multicycle_t tab_op [4] = '{M_MULTU, M_DIV, M_MTLO, M_MULT};
  logic [31:0] tab_a  [4] = '{32'hFFFF_FFFF, 32'd100, 32'h55, 32'h8000_0000};
  logic [31:0] tab_b  [4] = '{32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'd0, 32'd2};

  initial begin
    int t, t1, dc, nd;
    bus.req_valid = 1'b0;
    bus.req_op    = M_MULT;
    bus.a         = 32'b0;
    bus.b         = 32'b0;

    // Reset
    resetn = 1'b0;
    settle();
    chk_en = 1'b1;
    @(negedge clk);
    chk("reset_hi", bus.hi, 64'd0);
    chk("reset_lo", bus.lo, 64'd0);
    chk("reset_ready", bus.req_ready, 64'd1);
    chk("reset_busy", bus.busy, 64'd0);
    settle();
    resetn = 1'b1;
    settle();

    // MULT -2 * 3
    issue(M_MULT, 32'hFFFF_FFFE, 32'd3, t);
    wait_done(60, dc);
    chk("mult_done_lat", dc - t, 64'd3);
    @(negedge clk);
    chk("mult_hi", bus.hi, 64'hFFFF_FFFF);
    chk("mult_lo", bus.lo, 64'hFFFF_FFFA);
    settle();

    // DIVU 7 / 2
    issue(M_DIVU, 32'd7, 32'd2, t);
    chk("divu_md_div", acc_div, 64'd1);
    chk("divu_md_signed", acc_sgn, 64'd0);
    wait_done(60, dc);
    chk("divu_done_lat", dc - t, 64'd33);
    @(negedge clk);
    chk("divu_hi", bus.hi, 64'd1);
    chk("divu_lo", bus.lo, 64'd3);
    settle();

    // Accumulate from HI:LO = 0:5
    issue(M_MTLO, 32'd5, 32'd0, t);
    issue(M_MTHI, 32'd0, 32'd0, t);
`ifdef HILO_SCHED_ACCUM_EN
    issue(M_MADD, 32'd2, 32'd3, t);
    wait_done(60, dc);
    chk("madd_done_lat", dc - t, 64'd4);
    @(negedge clk);
    chk("madd_hi", bus.hi, 64'd0);
    chk("madd_lo", bus.lo, 64'd11);
    settle();
    issue(M_MSUB, 32'hFFFF_FFFF, 32'd20, t);
    wait_done(60, dc);
    @(negedge clk);
    chk("msub_lo", bus.lo, 64'd31);
    settle();
    issue(M_MTLO, 32'hFFFF_FFFF, 32'd0, t);
    issue(M_MADDU, 32'd1, 32'd1, t);
    wait_done(60, dc);
    @(negedge clk);
    chk("maddu_carry_hi", bus.hi, 64'd1);
    chk("maddu_carry_lo", bus.lo, 64'd0);
    settle();
    issue(M_MSUBU, 32'd1, 32'd1, t);
    wait_done(60, dc);
    @(negedge clk);
    chk("msubu_borrow_hi", bus.hi, 64'd0);
    chk("msubu_borrow_lo", bus.lo, 64'hFFFF_FFFF);
    settle();
`else
    nd = n_done;
    issue(M_MADD, 32'd2, 32'd3, t);
    repeat (10) settle();
    chk("madd_noop_done", n_done, nd);
    @(negedge clk);
    chk("madd_noop_hi", bus.hi, 64'd0);
    chk("madd_noop_lo", bus.lo, 64'd5);
    chk("madd_noop_ready", bus.req_ready, 64'd1);
    settle();
`endif

    // Flush of an in-flight DIV
    issue(M_MTHI, 32'hAB, 32'd0, t);
    issue(M_MTLO, 32'hCD, 32'd0, t);
    nd = n_done;
    issue(M_DIV, 32'd100, 32'd7, t);
    while (cyc < t + 10) settle();
    flushE = 1'b1;
    settle();
    flushE = 1'b0;
    @(negedge clk);
    chk("flush_ready_t11", bus.req_ready, 64'd1);
    chk("flush_hi", bus.hi, 64'hAB);
    chk("flush_lo", bus.lo, 64'hCD);
    settle();
    repeat (30) settle();
    chk("flush_no_done", n_done, nd);
    issue(M_MULTU, 32'h0001_0000, 32'h0001_0000, t);
    wait_done(60, dc);
    chk("multu_after_flush_lat", dc - t, 64'd3);
    @(negedge clk);
    chk("multu_hi", bus.hi, 64'd1);
    chk("multu_lo", bus.lo, 64'd0);
    settle();

    // MTHI presented while busy is held until the cycle after done
    issue(M_MULT, 32'd5, 32'd6, t);
    issue(M_MTHI, 32'h1234, 32'd0, t1);
    chk("mthi_was_held", issue_waits > 0, 64'd1);
    chk("mthi_accept_after_done", t1, last_done_cyc + 1);
    chk("mthi_accept_cycle", t1 - t, 64'd4);
    @(negedge clk);
    chk("mthi_hi", bus.hi, 64'h1234);
    chk("mthi_lo_from_mult", bus.lo, 64'd30);
    settle();

    // Flush in IDLE drops the request
    bus.req_valid = 1'b1;
    bus.req_op    = M_MULT;
    bus.a         = 32'd9;
    bus.b         = 32'd9;
    flushE        = 1'b1;
    @(negedge clk);
    chk("idle_flush_no_start", bus.md_start, 64'd0);
    settle();
    bus.req_valid = 1'b0;
    flushE        = 1'b0;
    @(negedge clk);
    chk("idle_flush_not_busy", bus.busy, 64'd0);
    settle();

    // Divide by zero and signed divide
    issue(M_DIVU, 32'd5, 32'd0, t);
    wait_done(60, dc);
    @(negedge clk);
    chk("div0_hi", bus.hi, 64'd5);
    chk("div0_lo", bus.lo, 64'hFFFF_FFFF);
    settle();
    issue(M_DIV, 32'hFFFF_FFF9, 32'd2, t);
    wait_done(60, dc);
    @(negedge clk);
    chk("div_signed_hi", bus.hi, 64'hFFFF_FFFF);
    chk("div_signed_lo", bus.lo, 64'hFFFF_FFFD);
    settle();

    // Back-to-back requests, checked by the model every cycle
    for (int i = 0; i < 4; i++) issue(tab_op[i], tab_a[i], tab_b[i], t);
    wait_done(60, dc);
    repeat (2) settle();

    // Reset in the middle of RUN
    issue(M_DIVU, 32'd9, 32'd2, t);
    while (cyc < t + 5) settle();
    resetn = 1'b0;
    settle();
    resetn = 1'b1;
    nd = n_done;
    @(negedge clk);
    chk("run_reset_hi", bus.hi, 64'd0);
    chk("run_reset_lo", bus.lo, 64'd0);
    chk("run_reset_ready", bus.req_ready, 64'd1);
    settle();
    repeat (40) settle();
    chk("run_reset_no_done", n_done, nd);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
